// File: rtl/niosii_irq_pkg.sv
// Shared constants for the Nios II interrupt aggregator: register map,
// bus width and the source-ID width helper.
package niosii_irq_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] ADDR_RAW     = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;

  // Source-ID width: max(1, clog2(n)), so a single source still gets one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/niosii_irq_prio_enc.sv
// Combinational lowest-set-bit encoder: bit 0 has the highest priority.
module niosii_irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    any = 1'b0;
    id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/niosii_irq_ctrl.sv
// Avalon-MM interrupt aggregator: latches level/edge requests per source,
// masks them, and drives a registered irq plus highest-priority source ID.
module niosii_irq_ctrl
  import niosii_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] edge_mode;
  logic               gie;

  logic [NUM_IRQ-1:0] wdata_src;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] active;
  logic               act_any;
  logic [ID_W-1:0]    act_id;
  logic [DATA_W-1:0]  rd_mux;

  logic wr_en;
  logic wr_pending;
  logic wr_enable;
  logic wr_edge;
  logic wr_ctrl;

  assign wdata_src  = writedata[NUM_IRQ-1:0];

  // Only the per-source bits and GIE are meaningful; the rest are dropped.
  if (NUM_IRQ < DATA_W) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[DATA_W-1:NUM_IRQ];
  end

  assign wr_en      = chipselect && !write_n;
  assign wr_pending = wr_en && (address == ADDR_PENDING);
  assign wr_enable  = wr_en && (address == ADDR_ENABLE);
  assign wr_edge    = wr_en && (address == ADDR_EDGE);
  assign wr_ctrl    = wr_en && (address == ADDR_CTRL);

  // Edge bits: a new rise beats a same-cycle W1C. Level bits follow irq_in
  // and ignore W1C entirely.
  assign rise        = irq_in & ~irq_prev;
  assign clr_mask    = wr_pending ? wdata_src : '0;
  assign pending_nxt = (edge_mode & (rise | (pending & ~clr_mask)))
                     | (~edge_mode & irq_in);

  assign active = pending & enable;

  niosii_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req (active),
    .any (act_any),
    .id  (act_id)
  );

  // Read mux, registered every cycle whether or not the slave is selected.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_RAW:     rd_mux = DATA_W'(irq_prev);
      ADDR_PENDING: rd_mux = DATA_W'(pending);
      ADDR_ENABLE:  rd_mux = DATA_W'(enable);
      ADDR_EDGE:    rd_mux = DATA_W'(edge_mode);
      ADDR_ACTIVE: begin
        rd_mux[DATA_W-1] = irq;
        rd_mux[ID_W-1:0] = irq_id;
      end
      ADDR_CTRL:    rd_mux[0] = gie;
      default:      rd_mux = '0;
    endcase
  end

  // All architectural state: source sampling, pending, config and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev  <= '0;
      pending   <= '0;
      enable    <= '0;
      edge_mode <= '0;
      gie       <= 1'b0;
      irq       <= 1'b0;
      irq_id    <= '0;
      readdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of the others (readdata sees the old pending, etc.).
      irq_prev <= irq_in;
      pending  <= pending_nxt;
      if (wr_enable) enable    <= wdata_src;
      if (wr_edge)   edge_mode <= wdata_src;
      if (wr_ctrl)   gie       <= writedata[0];
      irq      <= gie && act_any;
      if (act_any) irq_id <= act_id;
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_niosii_irq_ctrl.sv
// Directed bench for niosii_irq_ctrl: a table of single-cycle bus/irq vectors
// followed by hand-written multi-cycle sequences.
module tb_niosii_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [7:0]  irq_in = '0;
  logic        irq;
  logic [2:0]  irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  niosii_irq_ctrl #(.NUM_IRQ(8), .ID_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic [7:0]  src;
    logic [15:0] exp_rd;
    logic        exp_irq;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] a, input logic w, input logic [15:0] d,
                     input logic [7:0] s, input logic [15:0] rd,
                     input logic ei, input logic [2:0] eid);
    vec_t v;
    v.addr = a; v.wr = w; v.wdata = d; v.src = s;
    v.exp_rd = rd; v.exp_irq = ei; v.exp_id = eid;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Advance one edge and land 1 ns after it, where outputs are sampled
  // and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input string name, input logic [2:0] a,
                          input logic [15:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
    check(name, readdata, exp);
  endtask

  initial begin
    // addr wr wdata src | readdata irq id
    add(3'd5, 0, 16'h0000, 8'h00, 16'h0000, 0, 3'd0); // CTRL after reset
    add(3'd2, 1, 16'hFF5A, 8'h00, 16'h0000, 0, 3'd0); // ENABLE, upper bits dropped
    add(3'd2, 0, 16'h0000, 8'h00, 16'h005A, 0, 3'd0);
    add(3'd3, 1, 16'h00F0, 8'h00, 16'h0000, 0, 3'd0); // EDGE: bits 4..7 edge
    add(3'd3, 0, 16'h0000, 8'h00, 16'h00F0, 0, 3'd0);
    add(3'd5, 1, 16'h0001, 8'h00, 16'h0000, 0, 3'd0); // GIE on
    add(3'd5, 0, 16'h0000, 8'h00, 16'h0001, 0, 3'd0);
    add(3'd6, 1, 16'hFFFF, 8'h00, 16'h0000, 0, 3'd0); // unmapped write
    add(3'd7, 0, 16'h0000, 8'h00, 16'h0000, 0, 3'd0); // unmapped read
    add(3'd0, 0, 16'h0000, 8'h0A, 16'h0000, 0, 3'd0); // level bits 1,3 rise
    add(3'd0, 0, 16'h0000, 8'h0A, 16'h000A, 1, 3'd1); // RAW; irq 2 cycles later
    add(3'd1, 0, 16'h0000, 8'h0A, 16'h000A, 1, 3'd1);
    add(3'd4, 0, 16'h0000, 8'h00, 16'h8001, 1, 3'd1); // ACTIVE; sources drop
    add(3'd4, 0, 16'h0000, 8'h00, 16'h8001, 0, 3'd1); // irq falls, id holds
    add(3'd4, 0, 16'h0000, 8'h00, 16'h0001, 0, 3'd1);
    add(3'd1, 0, 16'h0000, 8'h20, 16'h0000, 0, 3'd1); // edge on bit 5
    add(3'd1, 0, 16'h0000, 8'h20, 16'h0020, 0, 3'd1); // masked by ENABLE
    add(3'd2, 1, 16'h0020, 8'h20, 16'h005A, 0, 3'd1); // enable bit 5
    add(3'd1, 0, 16'h0000, 8'h00, 16'h0020, 1, 3'd5);
    add(3'd1, 1, 16'h0020, 8'h00, 16'h0020, 1, 3'd5); // W1C bit 5
    add(3'd1, 0, 16'h0000, 8'h00, 16'h0000, 0, 3'd5);

    repeat (2) tick();
    reset = 1'b0;
    tick();

    foreach (vecs[k]) begin
      address    = vecs[k].addr;
      chipselect = 1'b1;
      write_n    = !vecs[k].wr;
      writedata  = vecs[k].wdata;
      irq_in     = vecs[k].src;
      tick();
      check($sformatf("vec%0d readdata", k), readdata, vecs[k].exp_rd);
      check($sformatf("vec%0d irq", k), 16'(irq), 16'(vecs[k].exp_irq));
      check($sformatf("vec%0d irq_id", k), 16'(irq_id), 16'(vecs[k].exp_id));
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Reset in the middle of traffic.
    irq_in = 8'hFF;
    tick();
    tick();
    check("pre-reset irq", 16'(irq), 16'd1);
    #2 reset = 1'b1;
    #1;
    check("reset irq", 16'(irq), 16'd0);
    check("reset irq_id", 16'(irq_id), 16'd0);
    check("reset readdata", readdata, 16'h0000);
    irq_in = 8'h00;
    tick();
    reset = 1'b0;
    bus_read("reset RAW", 3'd0, 16'h0000);
    bus_read("reset PENDING", 3'd1, 16'h0000);
    bus_read("reset ENABLE", 3'd2, 16'h0000);
    bus_read("reset CTRL", 3'd5, 16'h0000);

    // Edge latency on bit 0.
    bus_write(3'd2, 16'h0001);
    bus_write(3'd3, 16'h0001);
    bus_write(3'd5, 16'h0001);
    irq_in = 8'h01;
    tick();
    check("edge irq at N+1", 16'(irq), 16'd0);
    irq_in = 8'h00;
    tick();
    check("edge irq at N+2", 16'(irq), 16'd1);
    check("edge irq_id", 16'(irq_id), 16'd0);
    bus_read("edge PENDING", 3'd1, 16'h0001);
    bus_write(3'd1, 16'h0001);
    check("w1c irq +1", 16'(irq), 16'd1);
    tick();
    check("w1c irq +2", 16'(irq), 16'd0);

    // Level mode on bit 2.
    bus_write(3'd3, 16'h0000);
    bus_write(3'd2, 16'h0004);
    irq_in = 8'h04;
    tick();
    tick();
    check("level irq", 16'(irq), 16'd1);
    check("level irq_id", 16'(irq_id), 16'd2);
    bus_write(3'd1, 16'h0004);
    tick();
    tick();
    check("level w1c ignored irq", 16'(irq), 16'd1);
    bus_read("level PENDING", 3'd1, 16'h0004);
    irq_in = 8'h00;
    tick();
    check("level fall +1", 16'(irq), 16'd1);
    tick();
    check("level fall +2", 16'(irq), 16'd0);

    // Priority between simultaneous edge sources 3 and 5.
    bus_write(3'd3, 16'h00FF);
    bus_write(3'd2, 16'h00FF);
    irq_in = 8'h28;
    tick();
    tick();
    check("prio irq", 16'(irq), 16'd1);
    check("prio id 3", 16'(irq_id), 16'd3);
    bus_write(3'd1, 16'h0008);
    check("prio id after clr +1", 16'(irq_id), 16'd3);
    tick();
    check("prio id 5", 16'(irq_id), 16'd5);
    check("prio irq still", 16'(irq), 16'd1);
    bus_write(3'd1, 16'h0020);
    tick();
    check("prio all clear irq", 16'(irq), 16'd0);
    check("prio id holds", 16'(irq_id), 16'd5);
    irq_in = 8'h00;
    tick();

    // Set/clear collision on bit 1: the rising edge wins.
    irq_in = 8'h02;
    bus_write(3'd1, 16'h0002);
    bus_read("collision PENDING", 3'd1, 16'h0002);
    check("collision irq_id", 16'(irq_id), 16'd1);
    bus_write(3'd1, 16'h0002);
    irq_in = 8'h00;
    bus_read("collision cleared", 3'd1, 16'h0000);

    // Masking: pending edge on bit 4 held off by ENABLE, then by GIE.
    bus_write(3'd2, 16'h0000);
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    check("mask enable irq", 16'(irq), 16'd0);
    bus_write(3'd5, 16'h0000);
    bus_write(3'd2, 16'h0010);
    tick();
    tick();
    check("mask gie irq", 16'(irq), 16'd0);
    bus_write(3'd5, 16'h0001);
    check("gie latency irq", 16'(irq), 16'd0);
    tick();
    check("unmask irq", 16'(irq), 16'd1);
    check("unmask irq_id", 16'(irq_id), 16'd4);
    bus_read("ACTIVE read", 3'd4, 16'h8004);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
